multiply_signed_iterative: RTL and testbench
============================================

# multiply_signed_iterative

Parametrised sequential multiplier: one multiplier bit per clock (shift-and-add), selectable two's-complement or unsigned operands, start/done handshake. Successor to the 8x8 combinational signed array multiplier. Used where area matters more than latency, e.g. datapaths where one product per WIDTH cycles is sufficient. Produces the exact 2*WIDTH-bit product; no rounding, no truncation, no overflow.

## Interface
- WIDTH, default 8: operand width; must be even and >= 4.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- tc  input  1  operand format; 1 = two's complement, 0 = unsigned; captured with operands.
- multiplicand_a  input  WIDTH  multiplicand; captured on accepted start.
- multiplier_b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while a multiplication is in progress (state CALC).
- done  output  1  one-cycle pulse; product valid and updated.
- product  output  2*WIDTH  result; held until the next completion.

## Operation
- States: IDLE, CALC. Reset state IDLE.
- IDLE, start=1: capture a, b, tc; clear accumulator; bit counter = 0; go to CALC. IDLE, start=0: stay.
- CALC: each cycle examines multiplier bit[count] (LSB first).
  - Bit 1 and count < WIDTH-1: add the multiplicand to the upper accumulator half. The multiplicand is sign-extended when tc=1 and zero-extended when tc=0.
  - Bit 1, count = WIDTH-1, tc=1: subtract the multiplicand (MSB weight is negative).
  - Bit 1, count = WIDTH-1, tc=0: add.
  - Then shift the accumulator right one place. The shift is arithmetic when tc=1 and logical when tc=0.
- Upper accumulator half is WIDTH+1 bits wide; it must not overflow for any operand pair.
- After the CALC cycle with count = WIDTH-1: write the accumulator to product, pulse done, return to IDLE.
- Required result: product == a*b exactly.
  - tc=1: signed interpretation of a and b.
  - tc=0: unsigned interpretation.
- start while busy=1 is ignored; it is neither queued nor a restart. Input changes during CALC have no effect.
- No start during a done cycle: no effect. start=1 during a done cycle: accepted, because the state is already IDLE.

## Timing
- Reset values: busy=0, done=0, product=0, state IDLE, counter 0.
- start accepted at edge E0: busy=1 from E0 to E0+WIDTH.
- At edge E0+WIDTH: done=1 for exactly one cycle, product updated, busy=0.
- Latency from start cycle to done cycle: WIDTH clocks. Throughput: one product per WIDTH clocks, back-to-back.
- Reset asserted mid-operation: immediate abort; outputs go to their reset values; no done pulse; no partial product is written.
- product changes only at a done edge or at reset.

## Configuration
- MULTIPLY_ZERO_SKIP_EN.
- Defined: in IDLE, if start=1 and either operand equals 0, skip CALC. At E0+1: product=0, done=1, busy stays 0 throughout.
- Undefined: zero operands take the full WIDTH cycles, like any other operands; the result is still 0.
- Nonzero operands behave identically in both builds.

## Test plan
- WIDTH=8, tc=1, a=0x80, b=0x80 (-128 x -128) -> done 8 cycles after start, product=0x4000. Then a=0xFF, b=0x01 -> product=0xFFFF.
- WIDTH=8, tc=0, a=0xFF, b=0xFF -> product=0xFE01. Then tc=1 with the same operands -> product=0x0001.
- WIDTH=8: start held high through the operation with new operands a=3, b=5 presented after acceptance -> only the first result completes. A second start in the done cycle is accepted, and its done follows 8 cycles later.
- WIDTH=8: rst_n low 3 cycles after start -> busy=0, done never pulses, product=0. A new start afterwards gives the correct result.
- WIDTH=16, tc=1, random 1000 pairs, plus corner pairs (0x8000 x 0x7FFF, 0x8000 x 0x8000) -> matches reference model; done 16 cycles after each start.
- MULTIPLY_ZERO_SKIP_EN defined, a=0, b=0x5A -> done 1 cycle after start, product=0, busy never high. Undefined: the same stimulus gives done after WIDTH cycles.

Source files
------------

// File: rtl/multiply_signed_iterative_if.sv
`default_nettype none
//============================================================================
// Module   : multiply_signed_iterative_if
// Brief    : Start/done request bundle for the iterative multiplier.
// Revision : 1.0 - initial release
//============================================================================
interface multiply_signed_iterative_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 tc;
    logic [WIDTH-1:0]     multiplicand_a;
    logic [WIDTH-1:0]     multiplier_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, tc, multiplicand_a, multiplier_b,
        input  busy, done, product
    );

    modport slave (
        input  start, tc, multiplicand_a, multiplier_b,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/multiply_signed_iterative.sv
`default_nettype none
//============================================================================
// Module   : multiply_signed_iterative
// Brief    : Shift-and-add multiplier, one multiplier bit per clock, signed
//            (tc=1) or unsigned (tc=0), exact 2*WIDTH-bit product.
//            Optional MULTIPLY_ZERO_SKIP_EN: a zero operand completes in 1 cycle.
// Revision : 1.0 - initial release
//============================================================================
module multiply_signed_iterative #(
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    multiply_signed_iterative_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     count_q;
    logic [WIDTH-1:0]     a_q;
    logic                 tc_q;
    // {upper half (WIDTH+1), lower half}; lower half starts as the multiplier
    logic [2*WIDTH:0]     acc_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [2*WIDTH:0]     acc_d;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum_hi;
    logic                 last;

    assign last = (count_q == CNT_W'(WIDTH - 1));

    always_comb begin
        addend = {tc_q & a_q[WIDTH-1], a_q};
        sum_hi = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0]) begin
            // In two's complement the multiplier MSB carries negative weight
            if (last && tc_q) begin
                sum_hi = acc_q[2*WIDTH:WIDTH] - addend;
            end else begin
                sum_hi = acc_q[2*WIDTH:WIDTH] + addend;
            end
        end
        acc_d = {tc_q & sum_hi[WIDTH], sum_hi, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            a_q       <= '0;
            tc_q      <= 1'b0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.multiplicand_a;
                        tc_q    <= bus.tc;
                        acc_q   <= {{(WIDTH+1){1'b0}}, bus.multiplier_b};
                        count_q <= '0;
`ifdef MULTIPLY_ZERO_SKIP_EN
                        if ((bus.multiplicand_a == '0) || (bus.multiplier_b == '0)) begin
                            state_q <= S_ZERO;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (last) begin
                        product_q <= acc_d[2*WIDTH-1:0];
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        count_q   <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
`ifdef MULTIPLY_ZERO_SKIP_EN
                S_ZERO: begin
                    product_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_multiply_signed_iterative.sv
`default_nettype none
//============================================================================
// Module   : tb_multiply_signed_iterative
// Brief    : Self-checking bench: 8-bit vector table, handshake corner cases,
//            16-bit signed products against a reference multiply.
// Revision : 1.0 - initial release
//============================================================================
module tb_multiply_signed_iterative;
`ifdef MULTIPLY_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multiply_signed_iterative_if #(.WIDTH(8))  bus8  ();
    multiply_signed_iterative_if #(.WIDTH(16)) bus16 ();

    multiply_signed_iterative #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    multiply_signed_iterative #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    typedef struct {
        logic        tc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic op8(input logic t, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output int lat, output bit busy_seen);
        @(negedge clk);
        bus8.start = 1'b1; bus8.tc = t; bus8.multiplicand_a = a; bus8.multiplier_b = b;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0;
        busy_seen = bus8.busy;
        while (!bus8.done && lat < 64) begin
            @(negedge clk);
            lat++;
            busy_seen |= bus8.busy;
        end
        p = bus8.product;
    endtask

    task automatic op16(input logic t, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat);
        @(negedge clk);
        bus16.start = 1'b1; bus16.tc = t; bus16.multiplicand_a = a; bus16.multiplier_b = b;
        @(negedge clk);
        bus16.start = 1'b0;
        lat = 0;
        while (!bus16.done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        p = bus16.product;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!bus8.done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        logic [15:0]        p8;
        logic [31:0]        p16;
        logic signed [31:0] ref16;
        logic [15:0]        ra, rb;
        int                 lat;
        bit                 bsy;
        bit                 zero_op;
        bit                 seen_done;

        vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[4]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[6]  = '{1'b0, 8'h7F, 8'h80, 16'h3F80};
        vecs[7]  = '{1'b1, 8'h03, 8'h05, 16'h000F};
        vecs[8]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[9]  = '{1'b0, 8'hFD, 8'h05, 16'h04F1};
        vecs[10] = '{1'b1, 8'h00, 8'h5A, 16'h0000};
        vecs[11] = '{1'b0, 8'h5A, 8'h00, 16'h0000};
        vecs[12] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[13] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};

        rst_n = 1'b0;
        bus8.start = 1'b0;  bus8.tc = 1'b0;  bus8.multiplicand_a = '0;  bus8.multiplier_b = '0;
        bus16.start = 1'b0; bus16.tc = 1'b0; bus16.multiplicand_a = '0; bus16.multiplier_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus8.busy}, 32'd0);
        check("reset_done", {31'b0, bus8.done}, 32'd0);
        check("reset_product", {16'b0, bus8.product}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            op8(vecs[i].tc, vecs[i].a, vecs[i].b, p8, lat, bsy);
            zero_op = SKIP && ((vecs[i].a == 8'h00) || (vecs[i].b == 8'h00));
            check($sformatf("vec%0d_product", i), {16'b0, p8}, {16'b0, vecs[i].p});
            check($sformatf("vec%0d_latency", i), lat, zero_op ? 32'd1 : 32'd8);
            check($sformatf("vec%0d_busy", i), {31'b0, bsy}, zero_op ? 32'd0 : 32'd1);
        end

        // start held high; operands change after acceptance, then re-accepted in the done cycle
        @(negedge clk);
        bus8.start = 1'b1; bus8.tc = 1'b0; bus8.multiplicand_a = 8'h10; bus8.multiplier_b = 8'h02;
        @(negedge clk);
        bus8.multiplicand_a = 8'h03; bus8.multiplier_b = 8'h05;
        wait_done8(lat);
        check("hold_first_latency", lat, 32'd8);
        check("hold_first_product", {16'b0, bus8.product}, 32'h0020);
        @(negedge clk);
        bus8.start = 1'b0;
        check("hold_second_accepted", {31'b0, bus8.busy}, 32'd1);
        wait_done8(lat);
        check("hold_second_latency", lat, 32'd8);
        check("hold_second_product", {16'b0, bus8.product}, 32'h000F);

        // reset three cycles into an operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.tc = 1'b1; bus8.multiplicand_a = 8'h12; bus8.multiplier_b = 8'h34;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus8.busy}, 32'd0);
        check("abort_done", {31'b0, bus8.done}, 32'd0);
        check("abort_product", {16'b0, bus8.product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_done |= bus8.done;
        end
        check("abort_no_done", {31'b0, seen_done}, 32'd0);
        op8(1'b1, 8'h12, 8'h34, p8, lat, bsy);
        check("after_abort_product", {16'b0, p8}, 32'h03A8);
        check("after_abort_latency", lat, 32'd8);

        // 16-bit signed: corner pairs then random pairs against a reference multiply
        for (int i = 0; i < 1002; i++) begin
            if (i == 0) begin
                ra = 16'h8000; rb = 16'h7FFF;
            end else if (i == 1) begin
                ra = 16'h8000; rb = 16'h8000;
            end else begin
                ra = 16'($urandom); rb = 16'($urandom);
            end
            ref16 = $signed(ra) * $signed(rb);
            op16(1'b1, ra, rb, p16, lat);
            zero_op = SKIP && ((ra == 16'h0) || (rb == 16'h0));
            check($sformatf("w16_%0d_product", i), p16, ref16);
            check($sformatf("w16_%0d_latency", i), lat, zero_op ? 32'd1 : 32'd16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
